// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: PLL-lock reset sequencer and run/slow-run/halt/step clock-enable gate (optional cyc_cnt via CPUCLK_CYCLE_COUNTER_EN)
module cpu_clk_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int DIV_W = 8,
  parameter int AUTO_RUN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             brk,
  input  logic [DIV_W-1:0] div,
  output logic             cpu_rst,
  output logic             cpu_en,
`ifdef CPUCLK_CYCLE_COUNTER_EN
  output logic [31:0]      cyc_cnt,
`endif
  output logic [2:0]       state
);
  localparam logic [2:0] RESET_HOLD = 3'd0;
  localparam logic [2:0] WAIT_LOCK  = 3'd1;
  localparam logic [2:0] SETTLE     = 3'd2;
  localparam logic [2:0] RUN        = 3'd3;
  localparam logic [2:0] HALT       = 3'd4;
  localparam logic [2:0] STEP       = 3'd5;
  logic [2:0] nxt;
  logic [15:0] scnt;
  logic [DIV_W-1:0] dcnt;
  assign cpu_en = (state == RUN && dcnt == '0) || state == STEP;
  always_comb
    nxt = state == RESET_HOLD ? WAIT_LOCK :
          state == WAIT_LOCK  ? (locked ? SETTLE : WAIT_LOCK) :
          !locked             ? WAIT_LOCK :
          state == SETTLE     ? (scnt == '0 ? (AUTO_RUN != 0 ? RUN : HALT) : SETTLE) :
          state == RUN        ? ((halt_req || brk) ? HALT : RUN) :
          state == HALT       ? (halt_req ? HALT : step_req ? STEP : run_req ? RUN : HALT) :
          state == STEP       ? HALT : RESET_HOLD;
  always_ff @(posedge clk)
    if (rst) begin
      state   <= RESET_HOLD;
      cpu_rst <= 1'b1;
      scnt    <= '0;
      dcnt    <= '0;
    end else begin
      state   <= nxt;
      cpu_rst <= !(nxt == RUN || nxt == HALT || nxt == STEP);
      scnt    <= state == WAIT_LOCK ? 16'(SETTLE_CYCLES - 1) :
                 (state == SETTLE && scnt != '0) ? scnt - 1'b1 : scnt;
      dcnt    <= (state == RUN && nxt == RUN) ? (cpu_en ? div : dcnt - 1'b1) : '0;
    end
`ifdef CPUCLK_CYCLE_COUNTER_EN
  always_ff @(posedge clk)
    if (rst || nxt == WAIT_LOCK) cyc_cnt <= '0;
    else if (cpu_en) cyc_cnt <= cyc_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: scoreboard bench with a timestamp-based reference model of cpu_clk_ctrl
module tb_cpu_clk_ctrl;
  localparam int SETTLE = 16;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst, locked, run_req, halt_req, step_req, brk;
  logic [DW-1:0] div;
  logic cpu_rst, cpu_en;
  logic [2:0] state;
`ifdef CPUCLK_CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt;
`endif
  cpu_clk_ctrl #(.SETTLE_CYCLES(SETTLE), .DIV_W(DW), .AUTO_RUN(1)) dut (
    .clk(clk), .rst(rst), .locked(locked), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .brk(brk), .div(div), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
`ifdef CPUCLK_CYCLE_COUNTER_EN
    .cyc_cnt(cyc_cnt),
`endif
    .state(state));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] st;
    logic r;
    logic e;
    logic [31:0] c;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  // reference model: mode code, absolute cycle index, settle deadline and next enable time
  int m_st = 0;
  int t = 0;
  int settle_end = 0;
  int next_tick = 0;
  logic [31:0] m_cyc = 0;
  function automatic logic en_at(int s, int tt, int nt);
    return (s == 3 && tt == nt) || s == 5;
  endfunction
  task automatic drive(input logic r, input logic l, input logic rr, input logic hr,
                       input logic sr, input logic b, input logic [DW-1:0] d);
    exp_t e;
    int ns;
    rst = r; locked = l; run_req = rr; halt_req = hr; step_req = sr; brk = b; div = d;
    if (r) begin
      ns = 0;
      m_cyc = 0;
    end else begin
      if (en_at(m_st, t, next_tick)) begin
        m_cyc = m_cyc + 1;
        if (m_st == 3) next_tick = t + int'(d) + 1;
      end
      if (m_st == 0) ns = 1;
      else if (m_st == 1) begin
        ns = l ? 2 : 1;
        settle_end = t + SETTLE;
      end else if (!l) ns = 1;
      else if (m_st == 2) ns = (t == settle_end) ? 3 : 2;
      else if (m_st == 3) ns = (hr || b) ? 4 : 3;
      else if (m_st == 4) ns = hr ? 4 : sr ? 5 : rr ? 3 : 4;
      else ns = 4;
      if ((m_st != 3 && ns == 3)) next_tick = t + 1;
      if (ns == 1) m_cyc = 0;
    end
    m_st = ns;
    t = t + 1;
    e.st = 3'(ns);
    e.r = !(ns >= 3 && ns <= 5);
    e.e = en_at(ns, t, next_tick);
    e.c = m_cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  // monitor: compare each post-edge DUT output against the queued expectation
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (state !== e.st) begin bad++; $display("FAIL state t=%0t got=%0d want=%0d", $time, state, e.st); end
      total++;
      if (cpu_rst !== e.r) begin bad++; $display("FAIL cpu_rst t=%0t got=%b want=%b", $time, cpu_rst, e.r); end
      total++;
      if (cpu_en !== e.e) begin bad++; $display("FAIL cpu_en t=%0t got=%b want=%b", $time, cpu_en, e.e); end
`ifdef CPUCLK_CYCLE_COUNTER_EN
      total++;
      if (cyc_cnt !== e.c) begin bad++; $display("FAIL cyc_cnt t=%0t got=%0d want=%0d", $time, cyc_cnt, e.c); end
`endif
    end
  task automatic idle(input int n, input logic [DW-1:0] d);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(24, 8'd0);
    idle(12, 8'd3);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(2, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    idle(4, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    idle(4, 8'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    idle(2, 8'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    idle(5, 8'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    idle(22, 8'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 4000; i++)
      drive($urandom_range(299) == 0, $urandom_range(59) != 0, $urandom_range(9) == 0,
            $urandom_range(14) == 0, $urandom_range(3) == 0, $urandom_range(19) == 0,
            DW'($urandom_range(5)));
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
